// File: rtl/num_img_reg_reader_if.sv
// rtl/num_img_reg_reader_if.sv - command, count-register and tx byte stream bundle for num_img_reg_reader
//
// Ports (master = the reader, slave = its environment):
//   cmd_read_numimg            single-cycle read request from main control
//   busy                       reader occupied with a transaction
//   out_start_flush_numimg_reg one-cycle flush request to the count register
//   in_numimg_reg              {nav_count, science_count} from the count register
//   in_valid_numimg_reg        qualifies in_numimg_reg
//   tx_byte / tx_byte_valid / tx_byte_ready   framed response byte stream
//   done                       one-cycle end-of-transaction pulse
//   timeout_err                one-cycle pulse when the register never answered
//   last_nav_count / last_science_count       most recent successful capture
interface num_img_reg_reader_if;
    logic        cmd_read_numimg;
    logic        busy;
    logic        out_start_flush_numimg_reg;
    logic [31:0] in_numimg_reg;
    logic        in_valid_numimg_reg;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready;
    logic        done;
    logic        timeout_err;
    logic [15:0] last_nav_count;
    logic [15:0] last_science_count;

    modport master (
        input  cmd_read_numimg,
        input  in_numimg_reg,
        input  in_valid_numimg_reg,
        input  tx_byte_ready,
        output busy,
        output out_start_flush_numimg_reg,
        output tx_byte,
        output tx_byte_valid,
        output done,
        output timeout_err,
        output last_nav_count,
        output last_science_count
    );

    modport slave (
        output cmd_read_numimg,
        output in_numimg_reg,
        output in_valid_numimg_reg,
        output tx_byte_ready,
        input  busy,
        input  out_start_flush_numimg_reg,
        input  tx_byte,
        input  tx_byte_valid,
        input  done,
        input  timeout_err,
        input  last_nav_count,
        input  last_science_count
    );
endinterface

// File: rtl/num_img_reg_reader.sv
// rtl/num_img_reg_reader.sv - image-count register reader with 7-byte framed host response
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      num_img_reg_reader_if.master (command, count register, tx byte stream, status)
//
// Frame: HEADER, status, nav[15:8], nav[7:0], sci[15:8], sci[7:0], XOR of the first six.
module num_img_reg_reader #(
    parameter logic [7:0] HEADER_BYTE    = 8'hA5,
    parameter logic [7:0] ERR_STATUS     = 8'hEE,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    num_img_reg_reader_if.master bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Index of the final WAIT cycle: the counter starts at 0 on WAIT entry.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        busy_q, busy_d;
    logic        flush_q, flush_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cap_q, cap_d;
    logic [7:0]  status_q, status_d;
    logic [15:0] last_nav_q, last_nav_d;
    logic [15:0] last_sci_q, last_sci_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        cap_ok;
    logic        cap_err;
    logic [7:0]  checksum;
    logic [2:0]  next_idx;
    logic [7:0]  next_byte;

    // A valid in REQ or WAIT always wins, including on the final WAIT cycle.
    assign cap_ok  = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && bus.in_valid_numimg_reg;
    assign cap_err = (state_q == ST_WAIT) && !bus.in_valid_numimg_reg && (cnt_q == WAIT_LAST);

    // Built from the registered capture, so stalls cannot disturb it.
    assign checksum = HEADER_BYTE ^ status_q ^ cap_q[31:24] ^ cap_q[23:16]
                      ^ cap_q[15:8] ^ cap_q[7:0];

    assign next_idx = idx_q + 3'd1;

    always_comb begin
        next_byte = checksum;
        case (next_idx)
            3'd1:    next_byte = status_q;
            3'd2:    next_byte = cap_q[31:24];
            3'd3:    next_byte = cap_q[23:16];
            3'd4:    next_byte = cap_q[15:8];
            3'd5:    next_byte = cap_q[7:0];
            default: next_byte = checksum;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        flush_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        cap_d      = cap_q;
        status_d   = status_q;
        last_nav_d = last_nav_q;
        last_sci_d = last_sci_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;

        if (cap_ok) begin
            cap_d      = bus.in_numimg_reg;
            status_d   = 8'h00;
            last_nav_d = bus.in_numimg_reg[31:16];
            last_sci_d = bus.in_numimg_reg[15:0];
        end

        if (cap_err) begin
            cap_d     = 32'h0;
            status_d  = ERR_STATUS;
            timeout_d = 1'b1;
        end

        // Either outcome presents the header on the very next cycle.
        if (cap_ok || cap_err) begin
            state_d    = ST_SEND;
            tx_valid_d = 1'b1;
            tx_byte_d  = HEADER_BYTE;
            idx_d      = 3'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_read_numimg) begin
                    state_d = ST_REQ;
                    busy_d  = 1'b1;
                    flush_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (!bus.in_valid_numimg_reg) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_WAIT: begin
                if (!cap_ok && !cap_err) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && bus.tx_byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        tx_byte_d  = 8'h00;
                        state_d    = ST_DONE;
                    end else begin
                        idx_d     = next_idx;
                        tx_byte_d = next_byte;
                    end
                end
            end
            ST_DONE: begin
                // done and the busy release land together on leaving DONE.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            flush_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cap_q      <= 32'h0;
            status_q   <= 8'h00;
            last_nav_q <= 16'h0;
            last_sci_q <= 16'h0;
            idx_q      <= 3'd0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            flush_q    <= flush_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            cap_q      <= cap_d;
            status_q   <= status_d;
            last_nav_q <= last_nav_d;
            last_sci_q <= last_sci_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.busy                       = busy_q;
    assign bus.out_start_flush_numimg_reg = flush_q;
    assign bus.tx_byte                    = tx_byte_q;
    assign bus.tx_byte_valid              = tx_valid_q;
    assign bus.done                       = done_q;
    assign bus.timeout_err                = timeout_q;
    assign bus.last_nav_count             = last_nav_q;
    assign bus.last_science_count         = last_sci_q;

endmodule

// File: tb/tb_num_img_reg_reader.sv
// tb/tb_num_img_reg_reader.sv - self-checking bench for num_img_reg_reader
module tb_num_img_reg_reader;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    num_img_reg_reader_if bus();

    num_img_reg_reader #(
        .HEADER_BYTE   (8'hA5),
        .ERR_STATUS    (8'hEE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic        comb_en    = 1'b0;
    logic        dly_valid  = 1'b0;
    logic [31:0] resp_word  = 32'h0;
    logic        ready_r    = 1'b1;
    logic        cmd_r      = 1'b0;
    bit          stall_mode = 1'b0;

    assign bus.in_numimg_reg       = resp_word;
    assign bus.in_valid_numimg_reg = (comb_en & bus.out_start_flush_numimg_reg) | dly_valid;
    assign bus.tx_byte_ready       = ready_r;
    assign bus.cmd_read_numimg     = cmd_r;

    logic [7:0] exp_q[$];
    int xfer_cnt, done_cnt, flush_cnt, to_cnt;
    int first_cyc, done_cyc, to_cyc, cmd_cyc;
    bit prev_stall;
    logic [7:0] prev_byte;
    logic [15:0] exp_nav, exp_sci;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Frame model: header, status, the four data bytes MSB first, then XOR of all six.
    task automatic push_frame(input logic [7:0] st, input logic [31:0] w);
        logic [7:0] b [7];
        logic [7:0] x;
        b[0] = 8'hA5; b[1] = st;
        b[2] = w[31:24]; b[3] = w[23:16]; b[4] = w[15:8]; b[5] = w[7:0];
        x = 8'h00;
        for (int i = 0; i < 6; i++) x ^= b[i];
        b[6] = x;
        for (int i = 0; i < 7; i++) exp_q.push_back(b[i]);
    endtask

    task automatic push_bytes(input logic [55:0] v);
        for (int i = 0; i < 7; i++) exp_q.push_back(v[55 - 8*i -: 8]);
    endtask

    task automatic mon_step();
        if (!reset_n) begin
            prev_stall = 1'b0;
            return;
        end
        if (bus.out_start_flush_numimg_reg) flush_cnt++;
        if (bus.timeout_err) begin to_cnt++; to_cyc = cyc; end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_low_at_done", 32'(bus.busy), 32'd0);
        end
        if (bus.tx_byte_valid) begin
            chk("busy_during_send", 32'(bus.busy), 32'd1);
            if (first_cyc < 0) first_cyc = cyc;
            if (prev_stall) chk("byte_stable_in_stall", 32'(bus.tx_byte), 32'(prev_byte));
            if (bus.tx_byte_ready) begin
                xfer_cnt++;
                chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("tx_byte", 32'(bus.tx_byte), 32'(exp_q.pop_front()));
            end
        end
        prev_stall = bus.tx_byte_valid & !bus.tx_byte_ready;
        prev_byte  = bus.tx_byte;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        xfer_cnt = 0; done_cnt = 0; flush_cnt = 0; to_cnt = 0;
        first_cyc = -1; done_cyc = -1; to_cyc = -1;
    endtask

    task automatic start_cmd();
        cmd_r = 1'b1;
        tick();
        cmd_r = 1'b0;
        cmd_cyc = cyc;
        chk("busy_after_cmd", 32'(bus.busy), 32'd1);
        chk("flush_in_req", 32'(bus.out_start_flush_numimg_reg), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (bus.done) hit = 1'b1;
        end
        chk("done_seen", 32'(hit), 32'd1);
        tick();
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_xfers"}, xfer_cnt, 32'd7);
        chk({tag, "_done_pulses"}, done_cnt, 32'd1);
        chk({tag, "_bytes_left"}, exp_q.size(), 32'd0);
        chk({tag, "_flush_cycles"}, flush_cnt, 32'd1);
        chk({tag, "_last_nav"}, 32'(bus.last_nav_count), 32'(exp_nav));
        chk({tag, "_last_sci"}, 32'(bus.last_science_count), 32'(exp_sci));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_flush"}, 32'(bus.out_start_flush_numimg_reg), 32'd0);
        chk({tag, "_tx_byte"}, 32'(bus.tx_byte), 32'd0);
        chk({tag, "_tx_valid"}, 32'(bus.tx_byte_valid), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_timeout"}, 32'(bus.timeout_err), 32'd0);
        chk({tag, "_last_nav"}, 32'(bus.last_nav_count), 32'd0);
        chk({tag, "_last_sci"}, 32'(bus.last_science_count), 32'd0);
    endtask

    initial begin
        int busy_cycles;
        int valid_cycles;
        reset_n = 1'b0;
        clear_stats();
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        exp_nav = 16'h0;
        exp_sci = 16'h0;
        cmd_cyc = 0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk);
                #1;
                ready_r = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        tick();
        tick();
        check_zero("reset");
        reset_n = 1'b1;
        tick();

        // Immediate combinational response, no stalls, latency pinned.
        clear_stats();
        comb_en = 1'b1;
        resp_word = 32'h0003_0102;
        push_bytes(56'hA5_00_00_03_01_02_A5);
        exp_nav = 16'h0003; exp_sci = 16'h0102;
        start_cmd();
        wait_done(40);
        check_frame("imm");
        chk("imm_timeouts", to_cnt, 32'd0);
        chk("imm_first_byte_cycle", first_cyc, cmd_cyc + 1);
        chk("imm_done_latency", done_cyc - first_cyc, 32'd8);
        repeat (3) tick();

        // Delayed valid, with commands pulsed during WAIT and SEND.
        clear_stats();
        comb_en = 1'b0;
        resp_word = 32'hFFFF_0000;
        push_frame(8'h00, 32'hFFFF_0000);
        exp_nav = 16'hFFFF; exp_sci = 16'h0000;
        start_cmd();
        tick();
        tick();
        cmd_r = 1'b1;
        tick();
        cmd_r = 1'b0;
        tick();
        tick();
        dly_valid = 1'b1;
        tick();
        dly_valid = 1'b0;
        chk("dly_in_send", 32'(bus.tx_byte_valid), 32'd1);
        tick();
        tick();
        cmd_r = 1'b1;
        tick();
        cmd_r = 1'b0;
        wait_done(40);
        check_frame("dly");
        chk("dly_timeouts", to_cnt, 32'd0);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy) busy_cycles++;
        end
        chk("dly_no_extra_frame", busy_cycles, 32'd0);
        chk("dly_xfers_after_idle", xfer_cnt, 32'd7);

        // No response at all: timeout frame, captured counts untouched.
        clear_stats();
        push_bytes(56'hA5_EE_00_00_00_00_4B);
        start_cmd();
        wait_done(60);
        check_frame("tmo");
        chk("tmo_pulses", to_cnt, 32'd1);
        chk("tmo_cycle", to_cyc, cmd_cyc + 1 + TO);
        chk("tmo_first_byte_cycle", first_cyc, to_cyc);

        // Random ready stalls, same frame as the immediate case.
        clear_stats();
        comb_en = 1'b1;
        resp_word = 32'h0003_0102;
        push_bytes(56'hA5_00_00_03_01_02_A5);
        exp_nav = 16'h0003; exp_sci = 16'h0102;
        stall_mode = 1'b1;
        start_cmd();
        wait_done(300);
        stall_mode = 1'b0;
        check_frame("stall");

        // Command in the cycle right after done.
        clear_stats();
        resp_word = 32'h1234_ABCD;
        push_frame(8'h00, 32'h1234_ABCD);
        exp_nav = 16'h1234; exp_sci = 16'hABCD;
        start_cmd();
        wait_done(40);
        check_frame("b2b");
        chk("b2b_first_byte_cycle", first_cyc, cmd_cyc + 1);
        repeat (2) tick();

        // Reset while byte 3 is on the wire.
        clear_stats();
        resp_word = 32'h5A3C_0F11;
        push_frame(8'h00, 32'h5A3C_0F11);
        start_cmd();
        tick();
        tick();
        tick();
        #1;
        chk("rst_byte3_valid", 32'(bus.tx_byte_valid), 32'd1);
        chk("rst_byte3_value", 32'(bus.tx_byte), 32'h5A);
        chk("rst_xfers_before", xfer_cnt, 32'd2);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_zero("midrst");
        tick();
        tick();
        reset_n = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.tx_byte_valid) valid_cycles++;
        end
        chk("rst_no_bytes_after", valid_cycles, 32'd0);
        chk("rst_xfers_after", xfer_cnt, 32'd2);

        clear_stats();
        push_frame(8'h00, 32'h5A3C_0F11);
        exp_nav = 16'h5A3C; exp_sci = 16'h0F11;
        start_cmd();
        wait_done(40);
        check_frame("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
